// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU pin-level byte sequencer:
// state encoding, operation codes, word size and flag bit positions.
package fpu_pkg;

    localparam int BYTES_PER_WORD = 4;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_CMP = 2'd3;

    // core_flags = {NV, OF, UF, NX}
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NV = 3;

    typedef enum logic [2:0] {
        S_CMD,
        S_LOAD_A,
        S_LOAD_B,
        S_ISSUE,
        S_WAIT,
        S_SEND,
        S_FLAGS
    } seq_state_t;

endpackage

// File: rtl/fpu_io_sequencer.sv
// Byte-serial front end for the FP ALU core: takes a command byte and
// two LSB-first 32-bit operands, starts the core, waits for its result
// (with timeout), then streams four result bytes and one status byte.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_data/in_valid/in_ready       input byte stream (cmd, A, B)
//   core_a/core_b/core_op           operands and opcode to the core
//   core_start                      one-cycle start pulse
//   core_done/core_result/core_flags  core response
//   out_data/out_valid/out_ready    output byte stream (result, status)
//   busy                            high whenever not waiting for a command
module fpu_io_sequencer
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic [1:0]  core_op,
    output logic        core_start,
    input  logic        core_done,
    input  logic [31:0] core_result,
    input  logic [3:0]  core_flags,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES);
    localparam logic [1:0] CNT_LAST = 2'(BYTES_PER_WORD - 1);

    seq_state_t state, state_nx;

    logic [1:0]    cnt;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_inc;
    logic [31:0]   res_q;
    logic [3:0]    flags_q;
    logic          to_q;

    logic in_xfer;
    logic out_xfer;
    logic cnt_last;
    logic t_hit;

    assign in_ready   = (state == S_CMD) || (state == S_LOAD_A)
                     || (state == S_LOAD_B);
    assign out_valid  = (state == S_SEND) || (state == S_FLAGS);
    assign core_start = (state == S_ISSUE);
    assign busy       = (state != S_CMD);

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign cnt_last = (cnt == CNT_LAST);

    // The cycle whose increment lands on TIMEOUT_CYCLES is the last
    // wait cycle; a done pulse in that same cycle still takes priority.
    assign tcnt_inc = (tcnt == T_LAST) ? tcnt : tcnt + TW'(1);
    assign t_hit    = (tcnt_inc == T_LAST);

    always_comb begin
        out_data = 8'h00;
        if (state == S_SEND) begin
            out_data = res_q[{cnt, 3'b000} +: 8];
        end else if (state == S_FLAGS) begin
            out_data = {to_q, 3'b000, flags_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CMD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_CMD:    if (in_xfer) state_nx = S_LOAD_A;
            S_LOAD_A: if (in_xfer && cnt_last) state_nx = S_LOAD_B;
            S_LOAD_B: if (in_xfer && cnt_last) state_nx = S_ISSUE;
            S_ISSUE:  state_nx = S_WAIT;
            S_WAIT:   if (core_done || t_hit) state_nx = S_SEND;
            S_SEND:   if (out_xfer && cnt_last) state_nx = S_FLAGS;
            S_FLAGS:  if (out_xfer) state_nx = S_CMD;
            default:  state_nx = S_CMD;
        endcase
    end

    // Operand bytes are written straight into core_a/core_b, so the
    // core sees stable operands from S_ISSUE until the next command.
    // The 2-bit byte counter wraps to 0 after each word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            tcnt    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            to_q    <= 1'b0;
            core_a  <= '0;
            core_b  <= '0;
            core_op <= '0;
        end else begin
            case (state)
                S_CMD: begin
                    if (in_xfer) begin
                        core_op <= in_data[1:0];
                        cnt     <= '0;
                    end
                end
                S_LOAD_A: begin
                    if (in_xfer) begin
                        core_a[{cnt, 3'b000} +: 8] <= in_data;
                        cnt <= cnt + 2'd1;
                    end
                end
                S_LOAD_B: begin
                    if (in_xfer) begin
                        core_b[{cnt, 3'b000} +: 8] <= in_data;
                        cnt <= cnt + 2'd1;
                    end
                end
                S_ISSUE: begin
                    tcnt <= '0;
                end
                S_WAIT: begin
                    tcnt <= tcnt_inc;
                    if (core_done) begin
                        res_q   <= core_result;
                        flags_q <= core_flags;
                        to_q    <= 1'b0;
                    end else if (t_hit) begin
                        res_q   <= '0;
                        flags_q <= '0;
                        to_q    <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (out_xfer) cnt <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_io_sequencer.sv
// Self-checking bench for fpu_io_sequencer: transaction-level model
// of the byte protocol and core handshake, checked every cycle.
module tb_fpu_io_sequencer;

    localparam int T       = 255;
    localparam int NEVER   = 100000;
    localparam int NTXN    = 46;
    localparam int RST_TXN = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [1:0]  core_op;
    logic        core_start;
    logic        core_done;
    logic [31:0] core_result;
    logic [3:0]  core_flags;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    always #5 clk = ~clk;

    fpu_io_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .core_a(core_a),
        .core_b(core_b),
        .core_op(core_op),
        .core_start(core_start),
        .core_done(core_done),
        .core_result(core_result),
        .core_flags(core_flags),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // per-transaction plan
    logic [7:0]  plan [NTXN][9];
    int          dly  [NTXN];
    logic [31:0] res  [NTXN];
    logic [3:0]  flg  [NTXN];
    bit          stall[NTXN];
    int          vprob[NTXN];
    int          rprob[NTXN];

    task automatic set_txn(input int t, input logic [7:0] cmd,
                           input logic [31:0] a, input logic [31:0] b,
                           input int d, input logic [31:0] r,
                           input logic [3:0] f, input bit st,
                           input int vp, input int rp);
        plan[t][0] = cmd;
        for (int i = 0; i < 4; i++) begin
            plan[t][1+i] = a[8*i +: 8];
            plan[t][5+i] = b[8*i +: 8];
        end
        dly[t] = d; res[t] = r; flg[t] = f;
        stall[t] = st; vprob[t] = vp; rprob[t] = rp;
    endtask

    // Expected output byte i of transaction t.
    function automatic logic [7:0] exp_byte(input int t, input int i);
        logic [31:0] r;
        r = (dly[t] <= T) ? res[t] : 32'h0;
        if (i < 4) return r[8*i +: 8];
        return (dly[t] <= T) ? {4'b0000, flg[t]} : 8'h80;
    endfunction

    // model state
    int          txn = 0;
    int          nin = 0;
    int          k = -1;
    int          nout = 0;
    int          w;
    int          stall_cnt = 0;
    int          rst_hold = 0;
    int          starts = 0;
    int          dut_k = -1;
    int          first_k = -1;
    int          cyc = 0;
    logic [31:0] ma, mb;
    logic [1:0]  mop;
    logic [39:0] obsv;
    logic        e_in_ready, e_busy, e_start, e_out_valid;

    task automatic end_of_txn();
        case (txn)
            0: begin
                chk("t0_bytes", obsv, 40'h00_40_40_00_00);
                chk("t0_starts", starts, 1);
                chk("t0_latency", first_k, 4);
                chk("t0_op", core_op, 2'd0);
            end
            1: begin
                chk("t1_bytes", obsv, 40'h00_40_40_00_00);
                chk("t1_starts", starts, 1);
            end
            2: begin
                chk("t2_bytes", obsv, 40'h80_00_00_00_00);
                chk("t2_wait", first_k, T + 1);
                chk("t2_op", core_op, 2'd2);
            end
            3: begin
                chk("t3_bytes", obsv, 40'h01_12_34_56_78);
                chk("t3_wait", first_k, T + 1);
            end
            5: begin
                chk("t5_starts", starts, 1);
                chk("t5_op", core_op, 2'd1);
            end
            default: chk("starts", starts, 1);
        endcase
        txn++;
        nin = 0; k = -1; nout = 0; starts = 0;
        dut_k = -1; first_k = -1; obsv = '0; stall_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        core_done = 1'b0; core_result = '0; core_flags = '0;
        obsv = '0; ma = '0; mb = '0; mop = '0;

        set_txn(0, 8'h00, 32'h3F80_0000, 32'h4000_0000, 3,
                32'h4040_0000, 4'h0, 1'b0, 100, 100);
        set_txn(1, 8'h00, 32'h3F80_0000, 32'h4000_0000, 3,
                32'h4040_0000, 4'h0, 1'b1, 100, 100);
        set_txn(2, 8'h02, $urandom, $urandom, NEVER,
                $urandom, 4'($urandom), 1'b0, 100, 100);
        set_txn(3, 8'hFF, $urandom, $urandom, T,
                32'h1234_5678, 4'b0001, 1'b0, 100, 100);
        set_txn(4, 8'h03, $urandom, $urandom, 3,
                $urandom, 4'($urandom), 1'b0, 100, 100);
        set_txn(5, 8'h01, $urandom, $urandom, 5,
                $urandom, 4'($urandom), 1'b0, 80, 80);
        for (int t = 6; t < NTXN; t++) begin
            int sel, d;
            sel = $urandom_range(9);
            if (sel <= 5)      d = $urandom_range(1, 8);
            else if (sel == 6) d = T - 1;
            else if (sel == 7) d = T;
            else if (sel == 8) d = T + 1;
            else               d = NEVER;
            set_txn(t, 8'($urandom), $urandom, $urandom, d,
                    $urandom, 4'($urandom),
                    ($urandom_range(4) == 0),
                    $urandom_range(50, 100), $urandom_range(30, 100));
        end

        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", core_start, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_core_a", core_a, 32'h0);
        chk("rst_core_b", core_b, 32'h0);
        chk("rst_core_op", core_op, 2'd0);
        rst_n = 1'b1;

        while (txn < NTXN && cyc < 60000) begin
            @(negedge clk);
            cyc++;

            if (rst_hold > 0) begin
                chk("mid_rst_busy", busy, 1'b0);
                chk("mid_rst_in_ready", in_ready, 1'b1);
                chk("mid_rst_start", core_start, 1'b0);
                chk("mid_rst_out_valid", out_valid, 1'b0);
                chk("mid_rst_core_a", core_a, 32'h0);
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
                continue;
            end

            w = (dly[txn] < T) ? dly[txn] : T;
            e_in_ready  = (nin < 9);
            e_busy      = (nin != 0);
            e_start     = (nin == 9 && k == 0);
            e_out_valid = (nin == 9 && k > w);

            chk("in_ready", in_ready, e_in_ready);
            chk("busy", busy, e_busy);
            chk("core_start", core_start, e_start);
            chk("out_valid", out_valid, e_out_valid);
            if (e_out_valid)
                chk("out_data", out_data, exp_byte(txn, nout));
            if (nin == 9) begin
                chk("core_a", core_a, ma);
                chk("core_b", core_b, mb);
                chk("core_op", core_op, mop);
            end

            if (core_start) begin
                starts++;
                dut_k = 0;
            end else if (dut_k >= 0) begin
                dut_k++;
            end
            if (out_valid && first_k < 0) first_k = dut_k;

            if (txn == RST_TXN && nin == 3) begin
                rst_n = 1'b0;
                in_valid = 1'b0;
                core_done = 1'b0;
                out_ready = 1'b0;
                rst_hold = 3;
                txn++;
                nin = 0; k = -1; nout = 0; starts = 0;
                dut_k = -1; first_k = -1; obsv = '0;
                continue;
            end

            // drive inputs for the coming edge
            in_valid = ($urandom_range(99) < vprob[txn]);
            in_data  = (nin < 9) ? plan[txn][nin] : 8'($urandom);
            if (stall[txn])
                out_ready = e_out_valid && (stall_cnt >= 5);
            else
                out_ready = ($urandom_range(99) < rprob[txn]);
            if (nin == 9 && k == dly[txn]) begin
                core_done   = 1'b1;
                core_result = res[txn];
                core_flags  = flg[txn];
            end else begin
                core_done   = !(nin == 9 && k >= 1 && k <= w)
                              && ($urandom_range(9) == 0);
                core_result = $urandom;
                core_flags  = 4'($urandom);
            end

            // advance model
            if (nin == 9 && k >= 0) k++;
            if (in_valid && e_in_ready) begin
                if (nin == 0)     mop = in_data[1:0];
                else if (nin < 5) ma[8*(nin-1) +: 8] = in_data;
                else              mb[8*(nin-5) +: 8] = in_data;
                nin++;
                if (nin == 9) k = 0;
            end
            if (e_out_valid && out_ready) begin
                obsv[8*nout +: 8] = out_data;
                nout++;
                stall_cnt = 0;
                if (nout == 5) end_of_txn();
            end else if (e_out_valid) begin
                stall_cnt++;
            end
        end

        chk("all_txn_done", txn, NTXN);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
